// File: rtl/sonar_multi_ranger.sv
`default_nettype none
// ============================================================================
// sonar_multi_ranger: round-robin multi-channel ultrasonic ranger with echo
// timeout and per-channel near flags. Macro SONAR_NEAR_FILTER_EN debounces near.
// Rev 1.0
// ============================================================================
module sonar_multi_ranger #(
    parameter int N_CH       = 2,
    parameter int CLK_HZ     = 100_000_000,
    parameter int TRIG_US    = 10,
    parameter int SLOT_US    = 60_000,
    parameter int TIMEOUT_US = 30_000,
    parameter int THRESH_MM  = 600,
    parameter int HOLD_CNT   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH-1:0]      echo,
    output logic [N_CH-1:0]      trig,
    output logic [16*N_CH-1:0]   dist_mm,
    output logic                 dist_valid,
    output logic [2:0]           dist_ch,
    output logic [N_CH-1:0]      near,
    output logic [N_CH-1:0]      tmo
);
    localparam int TICK     = (CLK_HZ / 1_000_000 < 1) ? 1 : CLK_HZ / 1_000_000;
    localparam int TRIG_CLK = TRIG_US * TICK;
    localparam int WAIT_CLK = (TRIG_US + TIMEOUT_US) * TICK;
    localparam int SLOT_CLK = SLOT_US * TICK;

    typedef enum logic [2:0] {
        S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_DIVIDE, S_PUBLISH, S_HOLD
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            ch_q, ch_d;
    logic [31:0]           sc_q, sc_d;
    logic [31:0]           mph_q, mph_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [19:0]           quo_q, quo_d;
    logic [5:0]            rem_q, rem_d;
    logic [3:0]            dv_q, dv_d;
    logic                  to_q, to_d;
    logic [N_CH-1:0]       s1_q, s2_q, s3_q;
    logic [N_CH-1:0]       trig_q, trig_d;
    logic [16*N_CH-1:0]    dist_q;
    logic                  valid_q;
    logic [2:0]            dch_q;
    logic [N_CH-1:0]       near_q, tmo_q;

    logic                  w_echo_cur, w_echo_prev, w_rise, w_fall;
    logic [N_CH-1:0]       w_onehot;
    logic [2:0]            w_ch_next;
    logic [25:0]           w_step1, w_step2;
    logic [15:0]           w_res;
    logic                  w_raw_near;

    // One restoring shift-subtract step of the divide-by-58
    function automatic logic [25:0] div_step(input logic [5:0] r, input logic [19:0] q);
        logic [6:0] t;
        t = {r, q[19]};
        if (t >= 7'd58) return {6'(t - 7'd58), q[18:0], 1'b1};
        else            return {t[5:0], q[18:0], 1'b0};
    endfunction

    always_comb begin
        w_echo_cur  = 1'b0;
        w_echo_prev = 1'b0;
        w_onehot    = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (ch_q == 3'(k)) begin
                w_echo_cur  = s2_q[k];
                w_echo_prev = s3_q[k];
                w_onehot[k] = 1'b1;
            end
        end
    end

    assign w_rise     = w_echo_cur & ~w_echo_prev;
    assign w_fall     = ~w_echo_cur & w_echo_prev;
    assign w_ch_next  = (ch_q == 3'(N_CH - 1)) ? 3'd0 : ch_q + 3'd1;
    assign w_step1    = div_step(rem_q, quo_q);
    assign w_step2    = div_step(w_step1[25:20], w_step1[19:0]);
    assign w_res      = (to_q || (|quo_q[19:16])) ? 16'hFFFF : quo_q[15:0];
    assign w_raw_near = !to_q && (w_res <= 16'(THRESH_MM));

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        sc_d    = sc_q;
        mph_d   = mph_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dv_d    = dv_q;
        to_d    = to_q;
        if (state_q != S_IDLE) sc_d = sc_q + 32'd1;
        case (state_q)
            S_IDLE: begin
                state_d = S_TRIG;
                sc_d    = '0;
                to_d    = 1'b0;
            end
            S_TRIG: begin
                if (sc_q == 32'(TRIG_CLK - 1)) state_d = S_WAIT_RISE;
            end
            S_WAIT_RISE: begin
                if (w_rise) begin
                    // The detection cycle is already the first clock of the echo
                    state_d = S_MEASURE;
                    cnt_d   = (TICK == 1) ? 16'd1 : 16'd0;
                    mph_d   = (TICK == 1) ? 32'd0 : 32'd1;
                end else if (sc_q == 32'(WAIT_CLK - 1)) begin
                    to_d    = 1'b1;
                    state_d = S_PUBLISH;
                end
            end
            S_MEASURE: begin
                if (w_fall) begin
                    state_d = S_DIVIDE;
                    quo_d   = {1'b0, cnt_q, 3'b000} + {3'b000, cnt_q, 1'b0};
                    rem_d   = '0;
                    dv_d    = '0;
                end else if (w_echo_cur) begin
                    if (mph_q == 32'(TICK - 1)) begin
                        mph_d = '0;
                        if (cnt_q == 16'(TIMEOUT_US)) begin
                            to_d    = 1'b1;
                            state_d = S_PUBLISH;
                        end else begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end else begin
                        mph_d = mph_q + 32'd1;
                    end
                end
            end
            S_DIVIDE: begin
                // Two quotient bits per clock keeps publish latency short
                {rem_d, quo_d} = w_step2;
                dv_d = dv_q + 4'd1;
                if (dv_q == 4'd9) state_d = S_PUBLISH;
            end
            S_PUBLISH: state_d = S_HOLD;
            S_HOLD: begin
                // Leave one clock early so the IDLE cycle completes the slot
                if (sc_q >= 32'(SLOT_CLK - 2)) begin
                    state_d = S_IDLE;
                    ch_d    = w_ch_next;
                end
            end
            default: state_d = S_IDLE;
        endcase
        trig_d = (state_d == S_TRIG) ? w_onehot : '0;
    end

`ifdef SONAR_NEAR_FILTER_EN
    localparam int CW = $clog2(HOLD_CNT + 1);
    logic [CW-1:0] fc_q [N_CH];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            sc_q    <= '0;
            mph_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dv_q    <= '0;
            to_q    <= 1'b0;
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            trig_q  <= '0;
            dist_q  <= '1;
            valid_q <= 1'b0;
            dch_q   <= '0;
            near_q  <= '0;
            tmo_q   <= '0;
`ifdef SONAR_NEAR_FILTER_EN
            for (int k = 0; k < N_CH; k++) fc_q[k] <= '0;
`endif
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            sc_q    <= sc_d;
            mph_q   <= mph_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dv_q    <= dv_d;
            to_q    <= to_d;
            s1_q    <= echo;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            trig_q  <= trig_d;
            valid_q <= (state_q == S_PUBLISH);
            if (state_q == S_PUBLISH) begin
                dch_q <= ch_q;
                for (int k = 0; k < N_CH; k++) begin
                    if (ch_q == 3'(k)) begin
                        dist_q[16*k +: 16] <= w_res;
                        tmo_q[k]           <= to_q;
`ifdef SONAR_NEAR_FILTER_EN
                        if (w_raw_near != near_q[k]) begin
                            if (fc_q[k] == CW'(HOLD_CNT - 1)) begin
                                near_q[k] <= w_raw_near;
                                fc_q[k]   <= '0;
                            end else begin
                                fc_q[k] <= fc_q[k] + CW'(1);
                            end
                        end else begin
                            fc_q[k] <= '0;
                        end
`else
                        near_q[k] <= w_raw_near;
`endif
                    end
                end
            end
        end
    end

    assign trig       = trig_q;
    assign dist_mm    = dist_q;
    assign dist_valid = valid_q;
    assign dist_ch    = dch_q;
    assign near       = near_q;
    assign tmo        = tmo_q;
endmodule
`default_nettype wire

// File: tb/tb_sonar_multi_ranger.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_sonar_multi_ranger: directed bench for sonar_multi_ranger at 1 MHz clock.
// Rev 1.0
// ============================================================================
module tb_sonar_multi_ranger;
`ifdef SONAR_NEAR_FILTER_EN
    localparam int FILT   = 1;
    localparam int L_SLOT = 6000;
`else
    localparam int FILT   = 0;
    localparam int L_SLOT = 8000;
`endif
    localparam int L_TMO = 5000;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic [1:0]  echo = 2'b00;
    logic [1:0]  trig;
    logic [31:0] dist_mm;
    logic        dist_valid;
    logic [2:0]  dist_ch;
    logic [1:0]  near;
    logic [1:0]  tmo;

    int     nvec   = 0;
    int     nerr   = 0;
    int     nvalid = 0;
    longint cyc    = 0;

    sonar_multi_ranger #(
        .N_CH(2), .CLK_HZ(1_000_000), .TRIG_US(10), .SLOT_US(L_SLOT),
        .TIMEOUT_US(L_TMO), .THRESH_MM(600), .HOLD_CNT(4)
    ) dut (
        .clk(clk), .rst(rst), .echo(echo), .trig(trig), .dist_mm(dist_mm),
        .dist_valid(dist_valid), .dist_ch(dist_ch), .near(near), .tmo(tmo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (dist_valid) nvalid <= nvalid + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits for a trigger pulse, returns its pattern, start cycle and width
    task automatic wait_trig(output logic [1:0] tv, output longint t_rise, output int width);
        int n;
        n = 0;
        while (trig === 2'b00 && n < L_SLOT + 100) begin
            @(negedge clk);
            n++;
        end
        chk("trig_seen", 32'(trig !== 2'b00), 32'd1);
        tv     = trig;
        t_rise = cyc;
        n      = 0;
        while (trig !== 2'b00 && n < 100) begin
            @(negedge clk);
            n++;
        end
        width = n;
    endtask

    task automatic pulse_echo(input int ch, input int len);
        echo[ch] = 1'b1;
        repeat (len) @(negedge clk);
        echo[ch] = 1'b0;
    endtask

    task automatic wait_valid(input int bound, output int lat);
        int n;
        n = 0;
        while (dist_valid !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        lat = n;
        chk("valid_seen", 32'(dist_valid), 32'd1);
    endtask

    logic [1:0] tv;
    longint     t_prev, t_now;
    int         w, lat, nv0;
    int         flen [8] = '{580, 580, 580, 580, 580, 580, 3486, 580};
    logic [1:0] fexp [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_trig",  32'(trig), 32'd0);
        chk("rst_dist",  dist_mm, 32'hFFFF_FFFF);
        chk("rst_valid", 32'(dist_valid), 32'd0);
        chk("rst_ch",    32'(dist_ch), 32'd0);
        chk("rst_near",  32'(near), 32'd0);
        chk("rst_tmo",   32'(tmo), 32'd0);
        rst = 1'b0;

        // Slot 0, ch0: 580 us echo -> 100 mm
        wait_trig(tv, t_prev, w);
        chk("s0_trig", 32'(tv), 32'd1);
        chk("s0_width", 32'(w), 32'd10);
        repeat (20) @(negedge clk);
        pulse_echo(0, 580);
        wait_valid(40, lat);
        chk("s0_latency_le24", 32'(lat <= 24), 32'd1);
        chk("s0_ch",   32'(dist_ch), 32'd0);
        chk("s0_dist", dist_mm, 32'hFFFF_0064);
        chk("s0_tmo",  32'(tmo), 32'd0);
        chk("s0_near", 32'(near), (FILT != 0) ? 32'd0 : 32'd1);
        @(negedge clk);
        chk("s0_valid_one_clk", 32'(dist_valid), 32'd0);

        // Slot 1, ch1: no echo -> timeout 5000 us after trigger end
        wait_trig(tv, t_now, w);
        chk("s1_trig", 32'(tv), 32'd2);
        chk("s1_width", 32'(w), 32'd10);
        chk("s1_spacing", 32'(t_now - t_prev), 32'(L_SLOT));
        t_prev = t_now;
        wait_valid(L_TMO + 50, lat);
        chk("s1_tmo_time", 32'(lat >= L_TMO && lat <= L_TMO + 3), 32'd1);
        chk("s1_ch",   32'(dist_ch), 32'd1);
        chk("s1_dist", dist_mm, 32'hFFFF_0064);
        chk("s1_tmo",  32'(tmo), 32'd2);
        chk("s1_near", 32'(near), (FILT != 0) ? 32'd0 : 32'd1);

        // Slot 2, ch0: 3480 us -> 600 mm, threshold is inclusive
        wait_trig(tv, t_now, w);
        chk("s2_trig", 32'(tv), 32'd1);
        chk("s2_spacing", 32'(t_now - t_prev), 32'(L_SLOT));
        t_prev = t_now;
        repeat (20) @(negedge clk);
        pulse_echo(0, 3480);
        wait_valid(40, lat);
        chk("s2_dist", dist_mm, 32'hFFFF_0258);
        chk("s2_tmo",  32'(tmo), 32'd2);
        chk("s2_near", 32'(near), (FILT != 0) ? 32'd0 : 32'd1);

        // Slot 3, ch1: 3486 us -> 601 mm, clears ch1 timeout
        wait_trig(tv, t_now, w);
        chk("s3_trig", 32'(tv), 32'd2);
        chk("s3_width", 32'(w), 32'd10);
        chk("s3_spacing", 32'(t_now - t_prev), 32'(L_SLOT));
        t_prev = t_now;
        repeat (20) @(negedge clk);
        pulse_echo(1, 3486);
        wait_valid(40, lat);
        chk("s3_ch",   32'(dist_ch), 32'd1);
        chk("s3_dist", dist_mm, 32'h0259_0258);
        chk("s3_tmo",  32'(tmo), 32'd0);
        chk("s3_near", 32'(near), (FILT != 0) ? 32'd0 : 32'd1);

        // Slot 4, ch0: echo held high beyond the timeout
        wait_trig(tv, t_now, w);
        chk("s4_trig", 32'(tv), 32'd1);
        chk("s4_spacing", 32'(t_now - t_prev), 32'(L_SLOT));
        repeat (20) @(negedge clk);
        echo[0] = 1'b1;
        wait_valid(L_TMO + 100, lat);
        chk("s4_dist", dist_mm, 32'h0259_FFFF);
        chk("s4_tmo",  32'(tmo), 32'd1);
        chk("s4_near", 32'(near), 32'd0);
        echo[0] = 1'b0;

        // Slot 5, ch1: reset in the middle of the echo measurement
        wait_trig(tv, t_now, w);
        chk("s5_trig", 32'(tv), 32'd2);
        repeat (20) @(negedge clk);
        echo[1] = 1'b1;
        repeat (100) @(negedge clk);
        nv0 = nvalid;
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_trig",  32'(trig), 32'd0);
        chk("rst_mid_dist",  dist_mm, 32'hFFFF_FFFF);
        chk("rst_mid_tmo",   32'(tmo), 32'd0);
        chk("rst_mid_near",  32'(near), 32'd0);
        chk("rst_mid_valid", 32'(dist_valid), 32'd0);
        @(negedge clk);
        rst     = 1'b0;
        echo[1] = 1'b0;
        wait_trig(tv, t_now, w);
        chk("rst_next_trig", 32'(tv), 32'd1);
        chk("rst_no_publish", 32'(nvalid - nv0), 32'd0);

`ifdef SONAR_NEAR_FILTER_EN
        // ch0: three near then one far; ch1: four near
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                wait_trig(tv, t_now, w);
                chk("flt_trig", 32'(tv), 32'(2'b01 << (i % 2)));
            end
            repeat (20) @(negedge clk);
            pulse_echo(i % 2, flen[i]);
            wait_valid(40, lat);
            chk("flt_near", 32'(near), 32'(fexp[i]));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sonar_multi_ranger.md
SONAR_MULTI_RANGER -- requirements
Module: sonar_multi_ranger

Interface
REQ-001 SHALL provide parameter N_CH, default 2, number of ultrasonic channels (1..8).
REQ-002 SHALL provide parameter CLK_HZ, default 100_000_000, clk frequency; microsecond tick = CLK_HZ/1_000_000 clk.
REQ-003 SHALL provide parameter TRIG_US, default 10, trigger pulse width in us.
REQ-004 SHALL provide parameter SLOT_US, default 60_000, per-channel slot length in us, measured from trigger start.
REQ-005 SHALL provide parameter TIMEOUT_US, default 30_000, max wait for echo rise and max echo high time, in us.
REQ-006 SHALL provide parameter THRESH_MM, default 600, near threshold in mm.
REQ-007 SHALL provide parameter HOLD_CNT, default 4, consecutive agreeing measurements for near filter.
REQ-008 SHALL have ports: clk input 1 system clock; rst input 1 reset, asynchronous, active-high.
REQ-009 SHALL have ports: echo input N_CH raw sensor echo lines; trig output N_CH trigger pulses.
REQ-010 SHALL have ports: dist_mm output 16*N_CH, latest distance per channel, channel k at bits [16k+15:16k].
REQ-011 SHALL have ports: dist_valid output 1 one-clk publish strobe; dist_ch output 3 channel published.
REQ-012 SHALL have ports: near output N_CH proximity flags; tmo output N_CH last measurement timed out.

Function
REQ-013 SHALL synchronise each echo bit through two flops before any use; edges detected on synchronised value.
REQ-014 SHALL service channels round-robin 0,1,..,N_CH-1,0; exactly one channel active per slot.
REQ-015 SHALL run FSM IDLE->TRIG->WAIT_RISE->MEASURE->DIVIDE->PUBLISH->HOLD->IDLE (next channel).
REQ-016 TRIG SHALL drive trig[ch]=1 for exactly TRIG_US us, all other trig bits 0.
REQ-017 WAIT_RISE SHALL wait for a rising edge on echo[ch]; echo already high on entry is not an edge.
REQ-018 MEASURE SHALL count whole us while echo[ch] high, 16-bit counter, ending on falling edge.
REQ-019 DIVIDE SHALL compute dist = floor(echo_us*10/58) with a sequential shift-subtract divider, no combinational divide.
REQ-020 Result SHALL be published, dist_valid pulsed, within 24 clk of the echo falling edge at the pin.
REQ-021 No rise within TIMEOUT_US of trigger end, or echo high longer than TIMEOUT_US: dist=16'hFFFF, tmo[ch]=1, go to PUBLISH.
REQ-022 Successful measurement SHALL clear tmo[ch]; timed-out measurement counts as "far" for near logic.
REQ-023 Raw near condition: dist <= THRESH_MM and not timeout (equality is near).
REQ-024 HOLD SHALL wait until SLOT_US elapsed since trigger start, then advance channel; echo ignored in HOLD.
REQ-025 dist_mm/tmo/near for non-active channels SHALL hold their values.
REQ-026 N_CH=1 SHALL degenerate to repeated single-channel ranging, dist_ch always 0.

Reset
REQ-027 On rst: FSM IDLE, channel 0, trig=0, dist_mm=all 16'hFFFF, dist_valid=0, dist_ch=0, near=0, tmo=0, filter counters 0.
REQ-028 rst asserted mid-measurement SHALL abort immediately, trig low same cycle, no publish; first slot after release starts at channel 0.

Configuration
REQ-029 Macro SONAR_NEAR_FILTER_EN defined: near[ch] changes only after HOLD_CNT consecutive measurements on ch agree on the opposite raw state; disagreement resets that channel's counter.
REQ-030 Macro SONAR_NEAR_FILTER_EN undefined: near[ch] equals raw near of latest measurement, updated with dist_valid; HOLD_CNT unused.

Verification (CLK_HZ=1_000_000, N_CH=2, TIMEOUT_US=5000, SLOT_US=8000 unless noted)
REQ-031 Ch0 echo high 580 us after trigger -> dist_valid, dist_ch=0, dist_mm[15:0]=100, tmo[0]=0, near[0]=1 (filter off).
REQ-032 Echo 3480 us -> dist 600, near=1; echo 3486 us -> dist 601, near=0 (filter off).
REQ-033 Ch1 echo never rises -> publish 5000 us after trigger end, dist_mm[31:16]=16'hFFFF, tmo[1]=1, near[1]=0.
REQ-034 Observe 4 slots -> trig pulses ch0,ch1,ch0,ch1, each 10 us wide, starts 8000 us apart.
REQ-035 Filter on, HOLD_CNT=4: three near readings then one far -> near stays 0; four consecutive near -> near=1 on fourth dist_valid.
REQ-036 rst pulse during MEASURE on ch1 -> trig=0, no dist_valid, outputs at reset values, next trig on ch0.
